// File: rtl/fifo_burst_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_pkg
// Shared definitions for the FIFO burst reader: FSM state encoding and the
// depth of the output buffer that absorbs the FIFO's one-cycle read latency.
// -----------------------------------------------------------------------------
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a burst command
    READ  = 2'd1,  // pops still to be issued
    DRAIN = 2'd2   // all pops issued, words still undelivered
  } state_t;

  // Two entries cover one word in flight plus one word held under backpressure.
  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_burst_reader_obuf.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_obuf
// Two-entry in-order output buffer. Captures FIFO read data and presents the
// oldest entry to the downstream stream interface.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low reset
//   wr_en        write wr_data into the tail entry
//   wr_data      word to store
//   rd_en        head entry consumed (stream fire); only asserted when valid
//   flush        discard all entries; overrides wr_en and rd_en
//   count        number of stored entries (0..2)
//   head         oldest stored word
//   valid        count != 0
// -----------------------------------------------------------------------------
module fifo_burst_reader_obuf
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // NOTE: the storage entries are reset along with the pointers because the
  // head entry drives m_data directly, which must read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      // Simultaneous write and read leaves the count unchanged.
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Reader-side controller for a pop-based synchronous FIFO with one-cycle
// registered read latency. Accepts a burst command of cmd_len words, pops the
// FIFO, absorbs the read latency in a 2-entry buffer and streams the words out
// with valid/ready handshaking and last-word marking.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     burst command handshake; cmd_len words (0 legal)
//   abort                   synchronous abort of the active burst
//   fifo_empty/fifo_pop     FIFO flag in, pop strobe out
//   fifo_data               FIFO read data, valid the cycle after fifo_pop
//   m_valid/m_ready/m_data  output word stream
//   m_last                  final word of the burst (qualified by m_valid)
//   done                    one-cycle pulse on completion or abort
//   busy                    high whenever the FSM is not idle
//   words_sent              words delivered in the current or last burst
// Reset mid-burst drops any words already popped from the FIFO.
// -----------------------------------------------------------------------------
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  abort,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  done,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  words_sent
);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] pop_rem;
  logic [LEN_WIDTH-1:0] deliver_rem;
  logic                 inflight;
  logic                 done_q;
  logic [1:0]           buf_cnt;
  logic                 fire;
  logic                 last_fire;
  logic                 accept;
  logic                 abort_act;
  logic [2:0]           occupancy;

  assign fire      = m_valid && m_ready;
  assign m_last    = m_valid && (deliver_rem == LEN_WIDTH'(1));
  assign last_fire = fire && m_last;
  assign busy      = (state != IDLE);
  // Zero-length accepts and aborts complete through done_q (next cycle);
  // normal completion pulses on the final fire itself.
  assign done      = last_fire || done_q;

  // Words that will sit in the buffer after this edge if nothing new is popped.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, fire};

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    fifo_pop  = 1'b0;
    abort_act = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid && (cmd_len != '0)) state_nxt = READ;
      end
      READ: begin
        if (abort) begin
          abort_act = 1'b1;
          state_nxt = IDLE;
        end else begin
          fifo_pop = (pop_rem != '0) && !fifo_empty &&
                     (occupancy < 3'(BUF_DEPTH));
          if (fifo_pop && (pop_rem == LEN_WIDTH'(1))) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // A final fire coinciding with abort completes normally.
        if (last_fire) begin
          state_nxt = IDLE;
        end else if (abort) begin
          abort_act = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pop_rem     <= '0;
      deliver_rem <= '0;
      words_sent  <= '0;
      inflight    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_pop;
      done_q   <= (accept && (cmd_len == '0)) || abort_act;
      if (accept) begin
        pop_rem     <= cmd_len;
        deliver_rem <= cmd_len;
        words_sent  <= '0;
      end else begin
        if (abort_act) begin
          pop_rem     <= '0;
          deliver_rem <= '0;
        end else begin
          if (fifo_pop) pop_rem     <= pop_rem - LEN_WIDTH'(1);
          if (fire)     deliver_rem <= deliver_rem - LEN_WIDTH'(1);
        end
        // A word handed over in the abort cycle still counts as delivered.
        if (fire) words_sent <= words_sent + LEN_WIDTH'(1);
      end
    end
  end

  fifo_burst_reader_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight),
    .wr_data (fifo_data),
    .rd_en   (fire),
    .flush   (abort_act),
    .count   (buf_cnt),
    .head    (m_data),
    .valid   (m_valid)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Directed bench for fifo_burst_reader. A behavioural FIFO with one-cycle
// registered read data feeds the block; a monitor records delivered words,
// pops, done pulses, occupancy and output stability under backpressure.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int DW = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_pop;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          done;
  logic          busy;
  logic [LW-1:0] words_sent;

  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .done       (done),
    .busy       (busy),
    .words_sent (words_sent)
  );

  // Behavioural FIFO: pop at the edge, data registered for the next cycle.
  logic [DW-1:0] q[$];
  logic          push_req = 1'b0;
  logic [DW-1:0] push_val = '0;

  always @(posedge clk) begin
    if (fifo_pop && (q.size() != 0)) fifo_data <= q.pop_front();
    if (push_req) q.push_back(push_val);
    fifo_empty <= (q.size() == 0);
  end

  // Monitor: pre-edge values of the DUT outputs at every rising edge.
  logic [DW-1:0] rx[$];
  int            pop_cnt = 0;
  int            done_cnt = 0;
  int            empty_pops = 0;
  int            stall_errs = 0;
  int            held = 0;
  int            held_max = 0;
  logic          track_held = 1'b0;
  logic          stall_pending = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(posedge clk) begin
    if (fifo_pop) pop_cnt <= pop_cnt + 1;
    if (fifo_pop && fifo_empty) empty_pops <= empty_pops + 1;
    if (m_valid && m_ready) rx.push_back(m_data);
    if (done) done_cnt <= done_cnt + 1;
    if (reset && stall_pending && !(m_valid && (m_data === stall_data)))
      stall_errs <= stall_errs + 1;
    stall_pending <= reset && m_valid && !m_ready && !abort;
    stall_data    <= m_data;
    if (track_held) begin
      held <= held + int'(fifo_pop) - int'(m_valid && m_ready);
      if (held + int'(fifo_pop) - int'(m_valid && m_ready) > held_max)
        held_max <= held + int'(fifo_pop) - int'(m_valid && m_ready);
    end else begin
      held     <= 0;
      held_max <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_req = 1'b1;
      push_val = base + 64'(i);
      @(negedge clk);
    end
    push_req = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int limit);
    int base;
    base = done_cnt;
    for (int c = 0; c < limit && done_cnt == base; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check(tag, 64'(done_cnt - base), 64'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"},  64'(cmd_ready),  64'd1);
    check({pfx, "_busy"},       64'(busy),       64'd0);
    check({pfx, "_m_valid"},    64'(m_valid),    64'd0);
    check({pfx, "_m_data"},     m_data,          64'd0);
    check({pfx, "_m_last"},     64'(m_last),     64'd0);
    check({pfx, "_fifo_pop"},   64'(fifo_pop),   64'd0);
    check({pfx, "_done"},       64'(done),       64'd0);
    check({pfx, "_words_sent"}, 64'(words_sent), 64'd0);
  endtask

  initial begin
    int base_rx;
    int base_pop;
    int base_done;
    int pushed;

    // Reset values.
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    // Full-rate stream of 8 words 0x10..0x17.
    push_words(64'h10, 8);
    cmd_valid = 1'b1;
    cmd_len   = 16'd8;
    check("t1_cmd_ready", 64'(cmd_ready), 64'd1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check($sformatf("t1_pop_c%0d", c),   64'(fifo_pop), 64'(c <= 8));
      check($sformatf("t1_valid_c%0d", c), 64'(m_valid),  64'(c >= 3));
      if (c >= 3) check($sformatf("t1_data_c%0d", c), m_data, 64'h10 + 64'(c - 3));
      check($sformatf("t1_last_c%0d", c),  64'(m_last),   64'(c == 10));
      check($sformatf("t1_done_c%0d", c),  64'(done),     64'(c == 10));
    end
    @(negedge clk);
    check("t1_busy_after",  64'(busy),       64'd0);
    check("t1_words_sent",  64'(words_sent), 64'd8);
    check("t1_done_after",  64'(done),       64'd0);

    // Zero-length command.
    base_pop  = pop_cnt;
    cmd_valid = 1'b1;
    cmd_len   = 16'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t2_done",       64'(done),       64'd1);
    check("t2_busy",       64'(busy),       64'd0);
    check("t2_words_sent", 64'(words_sent), 64'd0);
    @(negedge clk);
    check("t2_done_clear", 64'(done),             64'd0);
    check("t2_busy_after", 64'(busy),             64'd0);
    check("t2_no_pops",    64'(pop_cnt - base_pop), 64'd0);

    // Backpressure with m_ready toggling 1,0,0,1.
    push_words(64'h20, 6);
    base_rx    = rx.size();
    base_pop   = pop_cnt;
    base_done  = done_cnt;
    track_held = 1'b1;
    cmd_valid  = 1'b1;
    cmd_len    = 16'd6;
    for (int c = 0; c < 80 && done_cnt == base_done; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      m_ready   = ((c % 4) == 0) || ((c % 4) == 3);
    end
    m_ready    = 1'b1;
    track_held = 1'b0;
    check("t3_done",       64'(done_cnt - base_done), 64'd1);
    check("t3_rx_count",   64'(rx.size() - base_rx),  64'd6);
    for (int i = 0; i < 6 && base_rx + i < rx.size(); i++)
      check($sformatf("t3_rx%0d", i), rx[base_rx + i], 64'h20 + 64'(i));
    check("t3_pops",       64'(pop_cnt - base_pop),   64'd6);
    check("t3_held_max",   64'(held_max),             64'd2);
    check("t3_stable",     64'(stall_errs),           64'd0);
    check("t3_words_sent", 64'(words_sent),           64'd6);

    // Starved FIFO: one word pushed every 3 cycles.
    base_rx   = rx.size();
    base_pop  = pop_cnt;
    base_done = done_cnt;
    pushed    = 0;
    cmd_valid = 1'b1;
    cmd_len   = 16'd4;
    for (int c = 0; c < 80 && done_cnt == base_done; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if ((c % 3) == 2 && pushed < 4) begin
        push_req = 1'b1;
        push_val = 64'h30 + 64'(pushed);
        pushed++;
      end else begin
        push_req = 1'b0;
      end
    end
    push_req = 1'b0;
    check("t4_done",        64'(done_cnt - base_done), 64'd1);
    check("t4_rx_count",    64'(rx.size() - base_rx),  64'd4);
    for (int i = 0; i < 4 && base_rx + i < rx.size(); i++)
      check($sformatf("t4_rx%0d", i), rx[base_rx + i], 64'h30 + 64'(i));
    check("t4_empty_pops",  64'(empty_pops),           64'd0);
    check("t4_pops",        64'(pop_cnt - base_pop),   64'd4);
    check("t4_words_sent",  64'(words_sent),           64'd4);

    // Abort after 3 words of a 10-word burst.
    push_words(64'h40, 12);
    base_rx   = rx.size();
    base_pop  = pop_cnt;
    cmd_valid = 1'b1;
    cmd_len   = 16'd10;
    for (int c = 0; c < 40 && (rx.size() - base_rx) < 3; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("t5_rx_before", 64'(rx.size() - base_rx), 64'd3);
    check("t5_busy",      64'(busy),                64'd1);
    abort   = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    abort   = 1'b0;
    m_ready = 1'b1;
    check("t5_done",       64'(done),              64'd1);
    check("t5_m_valid",    64'(m_valid),           64'd0);
    check("t5_busy_after", 64'(busy),              64'd0);
    check("t5_words_sent", 64'(words_sent),        64'd3);
    check("t5_cmd_ready",  64'(cmd_ready),         64'd1);
    check("t5_pops",       64'(pop_cnt - base_pop), 64'd5);
    @(negedge clk);
    check("t5_done_clear", 64'(done), 64'd0);

    // Follow-up burst picks up the next FIFO words.
    base_rx   = rx.size();
    cmd_valid = 1'b1;
    cmd_len   = 16'd2;
    run_until_done("t5b_done", 40);
    check("t5b_rx_count",  64'(rx.size() - base_rx), 64'd2);
    if (rx.size() >= base_rx + 2) begin
      check("t5b_rx0", rx[base_rx],     64'h45);
      check("t5b_rx1", rx[base_rx + 1], 64'h46);
    end
    check("t5b_words_sent", 64'(words_sent), 64'd2);

    // Asynchronous reset while in DRAIN with the buffer full.
    m_ready   = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = 16'd2;
    repeat (6) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("t6_busy",     64'(busy),     64'd1);
    check("t6_m_valid",  64'(m_valid),  64'd1);
    check("t6_m_data",   m_data,        64'h47);
    check("t6_fifo_pop", 64'(fifo_pop), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    reset   = 1'b1;
    m_ready = 1'b1;
    check("t6_cmd_ready_release", 64'(cmd_ready), 64'd1);

    // Recovery: the two words popped before reset are gone.
    base_rx   = rx.size();
    cmd_valid = 1'b1;
    cmd_len   = 16'd1;
    run_until_done("t6b_done", 40);
    check("t6b_rx_count", 64'(rx.size() - base_rx), 64'd1);
    if (rx.size() > base_rx) check("t6b_rx0", rx[base_rx], 64'h49);
    check("t6b_words_sent", 64'(words_sent), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Reader-side controller for the team's pop-based synchronous FIFO, which has 1-cycle registered read latency (data valid the cycle after pop). It accepts a burst command of N words, issues pops to the FIFO, absorbs the read latency in a 2-entry output buffer, and presents the words as a valid/ready stream with last-word marking. Sits between any FIFO instance and a downstream consumer such as a PE input or memory-write engine.

Parameters:
DATA_WIDTH, 64, word width; must match the FIFO's data width.
LEN_WIDTH, 16, width of the burst length and delivered-word counter.

Ports:
clk  in  1  clock; all logic rising-edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
cmd_valid  in  1  burst command valid.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_len  in  LEN_WIDTH  words to read in the burst; 0 is legal.
abort  in  1  synchronous abort of the current burst.
fifo_empty  in  1  FIFO empty flag.
fifo_pop  out  1  pop strobe to the FIFO.
fifo_data  in  DATA_WIDTH  FIFO data output, valid the cycle after fifo_pop.
m_valid  out  1  output word valid.
m_ready  in  1  downstream ready.
m_data  out  DATA_WIDTH  output word.
m_last  out  1  marks the final word of the burst; qualified by m_valid.
done  out  1  1-cycle pulse when the burst completes or is aborted.
busy  out  1  high whenever state != IDLE.
words_sent  out  LEN_WIDTH  words delivered in the current or last burst.

Behaviour:
- Reset (reset=0, async) drives the following values:
  - state = IDLE, fifo_pop = 0, m_valid = 0, m_data = 0, m_last = 0.
  - done = 0, busy = 0, words_sent = 0, cmd_ready = 1.
  - Internal pop-remaining, deliver-remaining, in-flight and buffer counts all clear to 0.
- States: IDLE, READ (pops outstanding), DRAIN (all pops issued, words still undelivered).
- IDLE:
  - cmd_ready = 1.
  - On cmd accept: load pop_rem = deliver_rem = cmd_len and clear words_sent.
  - If cmd_len = 0, the block stays IDLE and pulses done the next cycle with no pops. Otherwise go to READ.
- Pop rule (combinational from registers, fifo_empty and m_ready):
  - fifo_pop = (state == READ) && pop_rem != 0 && !fifo_empty && !abort && (buf_cnt + inflight - fire) < 2, where fire = m_valid && m_ready.
  - This sustains 1 word/cycle throughput with m_ready held high.
  - The block never pops an empty FIFO.
- Read-data capture:
  - inflight is the registered value of fifo_pop.
  - When inflight = 1, fifo_data is written into the buffer that cycle, even if the FIFO became empty meanwhile.
- Output buffer:
  - 2-entry in-order buffer; m_valid = buf_cnt != 0; m_data is the head entry.
  - Simultaneous write and fire keeps the count unchanged.
  - The buffer never overflows; the pop rule guarantees this.
- m_last = m_valid && deliver_rem == 1.
- On each fire: deliver_rem decrements and words_sent increments.
- Transitions and completion:
  - READ -> DRAIN when pop_rem reaches 0.
  - DRAIN -> IDLE on the fire with m_last. done pulses in that same cycle, as a combinational pulse on the final fire (registered-output variant not used).
- abort (READ or DRAIN):
  - No pop in the abort cycle; the buffer and inflight word are discarded.
  - Next cycle: state = IDLE, m_valid = 0, done = 1 for one cycle.
  - words_sent holds the count delivered before abort; a fire in the abort cycle still counts.
  - abort in IDLE is ignored.
- Backpressure: with m_ready low, m_valid and m_data stay stable until accepted, and popping stops once the buffer plus in-flight count reaches 2.
- Width: counters wrap modulo 2^LEN_WIDTH. A max cmd_len of 2^LEN_WIDTH-1 is supported.
- Reset mid-burst clears all state; words already popped from the FIFO are lost (documented, not recovered).

Decomposition:
- Shared package fifo_burst_reader_pkg:
  - state encoding (IDLE = 0, READ = 1, DRAIN = 2, 2 bits);
  - BUF_DEPTH = 2.
- Sub-module fifo_burst_reader_obuf: the 2-entry buffer with write, fire, flush, count, head data and m_valid.
- The top level holds the FSM, counters and pop logic.

Test Plan:
- Stream at full rate: FIFO preloaded with 8 words 0x10..0x17, cmd_len=8, m_ready=1.
  - Pops on 8 consecutive cycles; m_data 0x10..0x17 on consecutive cycles starting 2 cycles after cmd accept.
  - m_last on 0x17, done in the same cycle, words_sent=8.
- Zero length: cmd_len=0 -> no fifo_pop, done pulses next cycle, busy stays 0.
- Backpressure:
  - cmd_len=6 with m_ready toggling 1,0,0,1 repeating -> no more than 2 words held; m_data stable while m_ready=0.
  - Words delivered in order; total of 6 pops.
- Starved FIFO: cmd_len=4, FIFO empty, then push one word every 3 cycles -> fifo_pop never asserted while fifo_empty=1; 4 words delivered; done after the 4th.
- Abort mid-burst: cmd_len=10, abort asserted after 3 words delivered.
  - Next cycle: done=1, m_valid=0, state IDLE, words_sent=3.
  - A following cmd_len=2 is accepted and delivers the next FIFO words.
- Async reset: reset=0 mid-DRAIN between clock edges -> all outputs at reset values immediately; cmd_ready=1 after release.
